// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests under a
// credit limit, and buffers returning instructions in a small queue feeding decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Architectural fetch address and occupancy counters
  logic [XLEN-1:0] fetch_pc;
  cnt_t            count;
  cnt_t            outstanding;
  cnt_t            drop_cnt;

  // Instruction queue storage (read only through if_valid-gated outputs)
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  ptr_t            q_head;
  ptr_t            q_tail;

  // Tag FIFO: one PC per in-flight request, popped by every response
  logic [XLEN-1:0] tag_pc  [DEPTH];
  ptr_t            tag_head;
  ptr_t            tag_tail;

  logic            deq;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            enq;
  logic [CW:0]     occ;
  logic [CW:0]     limit;
  cnt_t            outstanding_nxt;
  logic [XLEN-1:0] redirect_aligned;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // imem_req_valid may drop without a transfer when decode stops draining the queue;
  // responses have no ready and are always consumed in the cycle they arrive.
  assign deq      = if_valid & if_ready;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_keep = imem_rsp_valid & (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign enq      = rsp_keep & ~redirect_valid;

  // Credit: every in-flight request must find a free queue slot when it returns
  assign occ   = {1'b0, outstanding} + {1'b0, count};
  assign limit = {1'b0, DEPTH_C} + (CW+1)'(deq);

  assign imem_req_valid = rst & (occ < limit);
  assign imem_req_addr  = fetch_pc;

  assign outstanding_nxt  = outstanding + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
  assign redirect_aligned = redirect_pc & ~(XLEN'(3));

  assign if_valid    = (count != '0);
  assign if_pc       = if_valid ? q_pc[q_head] : '0;
  assign if_pc_plus4 = if_valid ? q_pc[q_head] + XLEN'(4) : '0;
  assign if_instr    = if_valid ? q_instr[q_head] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (req_fire)       tag_tail <= tag_tail + ptr_t'(1);
      if (imem_rsp_valid) tag_head <= tag_head + ptr_t'(1);

      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the wrong path
        fetch_pc <= redirect_aligned;
        drop_cnt <= outstanding_nxt;
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
        if (deq)      q_head   <= q_head + ptr_t'(1);
        if (enq)      q_tail   <= q_tail + ptr_t'(1);
        count <= count + cnt_t'(enq) - cnt_t'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_pc[tag_tail] <= fetch_pc;
    if (enq) begin
      q_pc[q_tail]    <= tag_pc[tag_head];
      q_instr[q_tail] <= imem_rsp_data;
    end
  end

  // Counter range invariants; any firing indicates a broken credit scheme
  always @(posedge clk) begin
    if (rst) begin
      assert (!(req_fire && outstanding == DEPTH_C));
      assert (!(imem_rsp_valid && outstanding == '0));
      assert (!(enq && !deq && count == DEPTH_C));
      assert (drop_cnt <= outstanding);
      assert (occ <= {1'b0, DEPTH_C});
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency, an
// address/PC reference model and a delivery scoreboard, plus directed scenarios.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic [31:0] exp_q[$];
  mem_t        mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] sb_e;
  mem_t        sb_m;

  fetch_queue #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Clock and cycle counter
  always #5 clk = ~clk;

  // Instruction memory: fixed latency, in order, no backpressure
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Scoreboard: requests push expected PCs, deliveries pop and compare
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (if_valid && if_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_delivery got_pc=%h expected none", if_pc);
        end else begin
          sb_e = exp_q.pop_front();
          if (if_pc !== sb_e) begin
            errors++;
            $display("FAIL sb_pc got=%h exp=%h", if_pc, sb_e);
          end
          checks++;
          if (if_instr !== instr_of(sb_e)) begin
            errors++;
            $display("FAIL sb_instr got=%h exp=%h", if_instr, instr_of(sb_e));
          end
          checks++;
          if (if_pc_plus4 !== sb_e + 32'd4) begin
            errors++;
            $display("FAIL sb_pc_plus4 got=%h exp=%h", if_pc_plus4, sb_e + 32'd4);
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== model_pc) begin
          errors++;
          $display("FAIL sb_req_addr got=%h exp=%h", imem_req_addr, model_pc);
        end
        exp_q.push_back(model_pc);
        sb_m.addr = imem_req_addr;
        sb_m.due  = cyc + mem_lat;
        mem_q.push_back(sb_m);
        acc_log.push_back(imem_req_addr);
        model_pc = model_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc & ~32'h3;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat = 1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_if_pc_plus4 got=%h exp=0", if_pc_plus4); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_basic_fetch();
    logic exp_v;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = (k >= 2);
      checks++;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid k=%0d got=%b exp=1", k, imem_req_valid); end
      checks++;
      if (imem_req_addr !== 32'(4 * k)) begin errors++; $display("FAIL basic_req_addr got=%h exp=%h", imem_req_addr, 32'(4 * k)); end
      checks++;
      if (if_valid !== exp_v) begin errors++; $display("FAIL basic_if_valid k=%0d got=%b exp=%b", k, if_valid, exp_v); end
      if (k >= 2) begin
        checks++;
        if (if_pc !== 32'(4 * (k - 2))) begin errors++; $display("FAIL basic_if_pc got=%h exp=%h", if_pc, 32'(4 * (k - 2))); end
        checks++;
        if (if_pc_plus4 !== 32'(4 * (k - 1))) begin errors++; $display("FAIL basic_if_pc_plus4 got=%h exp=%h", if_pc_plus4, 32'(4 * (k - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    mem_lat = 1;
    if_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stall_fill_req got_v=%b got_a=%h exp_a=%h", imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid i=%0d got=%b exp=0", i, imem_req_valid); end
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold_head i=%0d got_v=%b got_pc=%h exp_pc=0", i, if_valid, if_pc);
      end
      tick();
    end
    if_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * j)) begin
        errors++;
        $display("FAIL stall_release j=%0d got_v=%b got_pc=%h exp_pc=%h", j, if_valid, if_pc, 32'(4 * j));
      end
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    int n;
    mem_lat = 3;
    if_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdi_credit got=%b exp=0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL rdi_wrong_path i=%0d got_pc=%h exp=no valid", i, if_pc); end
      tick();
    end
    n = 0;
    @(negedge clk);
    while (!if_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (if_valid !== 1'b1) begin errors++; $display("FAIL rdi_timeout got=%b exp=1", if_valid); end
    checks++;
    if (if_pc !== 32'h0000_0100) begin errors++; $display("FAIL rdi_first_pc got=%h exp=00000100", if_pc); end
    tick();
    repeat (6) tick();
  endtask

  task automatic test_redirect_same_cycle();
    int n;
    mem_lat = 1;
    if_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rds_req_in_redirect got=%b exp=1", imem_req_valid); end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      errors++;
      $display("FAIL rds_head_unmasked got_v=%b got_pc=%h exp_pc=00000004", if_valid, if_pc);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL rds_next_req got_v=%b got_a=%h exp_a=00000200", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rds_flushed got=%b exp=0", if_valid); end
    n = 0;
    while (!if_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      errors++;
      $display("FAIL rds_first_pc got_v=%b got_pc=%h exp_pc=00000200", if_valid, if_pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    int n;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete();
    n = 0;
    while (acc_log.size() < 2 && n < 20) begin tick(); n++; end
    checks++;
    if (acc_log.size() < 2) begin
      errors++;
      $display("FAIL wrap_timeout got=%0d exp=2 requests", acc_log.size());
    end else begin
      checks++;
      if (acc_log[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_addr got=%h exp=fffffffc", acc_log[0]); end
      checks++;
      if (acc_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got=%h exp=00000000", acc_log[1]); end
    end
    n = 0;
    @(negedge clk);
    while (!if_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4 got_pc=%h got_p4=%h exp_pc=fffffffc exp_p4=00000000", if_pc, if_pc_plus4);
    end
    tick();
    repeat (3) tick();
  endtask

  task automatic test_reset_midstream();
    int n;
    if_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_full got_v=%b got_req=%b exp_v=1 exp_req=0", if_valid, imem_req_valid);
    end
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_q.delete();
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL mrst_immediate got_v=%b got_pc=%h exp_v=0 exp_pc=0", if_valid, if_pc);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    rst = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL mrst_restart got_v=%b got_a=%h exp_a=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    n = 0;
    while (!if_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
      errors++;
      $display("FAIL mrst_first_pc got_v=%b got_pc=%h exp_pc=%h", if_valid, if_pc, RESET_PC);
    end
    tick();
  endtask

  task automatic test_back_to_back_random();
    int n;
    mem_lat = 2;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 30) begin tick(); n++; end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got=%0d pending exp=0", exp_q.size()); end
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rand_empty got=%b exp=0", if_valid); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_midstream();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage immediately downstream of `program_counter`. It owns the architectural fetch address and issues in-order requests to instruction memory over a valid/ready handshake. It buffers returning instructions in a small in-order queue and presents them, with their PC, to decode through a valid/ready handshake. A redirect from execute flushes the queue and discards in-flight responses, so wrong-path instructions never reach decode.

## Interface
- `XLEN`, 32, address/instruction width
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `DEPTH`, 2, queue entries and maximum outstanding-plus-queued instructions (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `redirect_valid`  in  1  branch/jump taken; load new fetch PC
- `redirect_pc`  in  XLEN  redirect target (bits [1:0] ignored, forced 0)
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  XLEN  fetch address
- `imem_rsp_valid`  in  1  instruction returned, in request order, latency ≥1 cycle, no backpressure
- `imem_rsp_data`  in  XLEN  instruction word
- `if_valid`  out  1  queue head valid
- `if_ready`  in  1  decode accepts head
- `if_pc`  out  XLEN  PC of head instruction
- `if_pc_plus4`  out  XLEN  `if_pc` + 4, mod 2^XLEN
- `if_instr`  out  XLEN  head instruction

## Operation
- State: `fetch_pc`; queue of DEPTH {pc, instr} entries with head/tail pointers and a count; `outstanding` counter (0..DEPTH); `drop_cnt` (0..DEPTH); a pc FIFO tagging in-flight requests.
- Credit: `imem_req_valid` = (`outstanding` + `count` − `deq` < DEPTH), where `deq` = `if_valid & if_ready`. Because responses cannot be stalled, this guarantees a queue slot exists for every response.
- Request accepted (`imem_req_valid & imem_req_ready`): `imem_req_addr` = `fetch_pc`; `fetch_pc` += 4 (wraps mod 2^XLEN); `outstanding`++; the address is pushed to the tag FIFO.
- Response with `drop_cnt` = 0: enqueue {tag pc, data}; `outstanding`−−.
- Response with `drop_cnt` > 0: discard; `drop_cnt`−−; `outstanding`−−.
- Dequeue on `if_valid & if_ready`. `if_*` are driven from queue storage, not from `imem_rsp_data`.
- Redirect, effective at the next edge:
  - `fetch_pc` ← `redirect_pc & ~3`; the queue is emptied.
  - `drop_cnt` ← `outstanding` after this cycle's accept and response updates. A request accepted in the redirect cycle is counted as to-be-dropped, and a response arriving in the redirect cycle is discarded.
  - Redirect wins over the `fetch_pc` +4 increment.
- Redirect does not mask `if_valid` in its own cycle. A handshake in that cycle completes, and downstream kills that instruction.
- Counters must never over- or underflow. Any over/underflow is a design error; assert it in simulation.

## Timing
- Reset (`rst` = 0), asynchronous:
  - `fetch_pc` = RESET_PC; `count`, `outstanding`, `drop_cnt` = 0.
  - `if_valid` = 0, `if_pc` = 0, `if_pc_plus4` = 0, `if_instr` = 0, `imem_req_valid` = 0.
- `imem_req_addr` = `fetch_pc` at all times, so it equals RESET_PC during reset.
- First request: `imem_req_valid` = 1 in the first cycle after `rst` deasserts.
- Latency: a response at edge N is visible on `if_*` after edge N+1. With 1-cycle memory, request to `if_valid` = 2 cycles.
- Throughput: with 1-cycle memory and `if_ready` held 1, one instruction per cycle sustained.
- Queue full and `if_ready` = 0: requests stop; no instruction is lost or duplicated.
- Reset asserted mid-transaction: all state clears immediately. Responses to pre-reset requests are the memory's responsibility and are not tracked.

## Test plan
- Reset, then release with 1-cycle memory and `if_ready` = 1 -> `imem_req_addr` 0,4,8,… one per cycle. `if_valid` rises 2 cycles after the first request; `if_pc` = 0,4,8 back-to-back; `if_pc_plus4` = `if_pc`+4.
- `if_ready` = 0 for 10 cycles -> exactly 2 instructions held (pc 0,4) and `imem_req_valid` = 0. On release, 0,4,8 are delivered in order with no gaps or duplicates.
- 3-cycle memory, redirect to 0x100 while 2 requests are in flight -> both responses are dropped; the next `if_pc` is 0x100.
- Redirect to 0x203 in the same cycle as a response and a request accept -> both are dropped; `imem_req_addr` = 0x200 the next cycle; first delivered `if_pc` = 0x200.
- `fetch_pc` at 0xFFFF_FFFC -> the following request address wraps to 0x0; `if_pc_plus4` = 0x0 for that entry.
- `rst` asserted for 1 cycle mid-stream with the queue full -> `if_valid` = 0 immediately; fetching restarts at RESET_PC.
